daq_chan_fifo_writer: RTL and testbench

Write-side controller for the 16 per-channel sample FIFOs in the DAQ path. On each L1A it captures SAMP_MAX+1 consecutive 16-channel ADC samples into all channel FIFOs in parallel and counts stored events. It raises RDY for the per-channel readout sequencer and consumes that sequencer's per-event done pulse. It also supports the JTAG direct-write mode.

---
 rtl/daq_chan_fifo_writer.sv | 254 +++++++++++++++++++++++++
 tb/tb_daq_chan_fifo_writer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_chan_fifo_writer.sv
// ============================================================================
// daq_chan_fifo_writer
// ----------------------------------------------------------------------------
// Write-side controller for the per-channel sample FIFOs of the DAQ path.
// Each accepted trigger (L1A) captures SAMP_MAX+1 consecutive ADC sample sets.
// Every channel FIFO is written in parallel with its lane of ADC_DIN. The block
// counts the complete events held in the FIFOs. RDY tells the readout
// sequencer that an event is available, and the sequencer's EVT_DONE pulse
// releases one event. A JTAG direct-write mode bypasses the capture machine
// so the FIFOs can be loaded by hand.
//
// Build option:
//   DAQ_TRIG_QUEUE_EN  defined   -> up to 7 pending triggers are queued;
//                                   an L1A with the queue full is dropped.
//                      undefined -> one trigger at a time; an L1A outside
//                                   IDLE, with one already pending, or with
//                                   the event store full is dropped.
//   Any dropped L1A sets the sticky OVFL flag.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   synchronous, active-low reset
//   JTAG_MODE  in   1 = direct-write mode, capture machine held idle
//   WR_FIFO    in   write strobe to all channels in JTAG mode
//   L1A        in   trigger, one-cycle pulse
//   SAMP_MAX   in   samples per event minus one
//   ADC_VALID  in   one strobe per new sample set on ADC_DIN
//   ADC_DIN    in   channel n occupies bits [DW*n +: DW]
//   EVT_DONE   in   reader finished one event (one-cycle pulse)
//   WR_ENA     out  channel FIFO write enables (all bits identical)
//   DOUT       out  registered write data to the channel FIFOs
//   RDY        out  at least one complete event is stored
//   EVT_CNT    out  number of complete events stored
//   OVFL       out  sticky: an L1A was dropped
// ============================================================================
module daq_chan_fifo_writer #(
  parameter int NCHAN   = 16,
  parameter int DW      = 12,
  parameter int MAX_EVT = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                JTAG_MODE,
  input  logic                WR_FIFO,
  input  logic                L1A,
  input  logic [6:0]          SAMP_MAX,
  input  logic                ADC_VALID,
  input  logic [NCHAN*DW-1:0] ADC_DIN,
  input  logic                EVT_DONE,
  output logic [NCHAN-1:0]    WR_ENA,
  output logic [NCHAN*DW-1:0] DOUT,
  output logic                RDY,
  output logic [3:0]          EVT_CNT,
  output logic                OVFL
);

  // --------------------------------------------------------------------------
  // Capture state machine encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE = 2'd0;  // waiting for a pending trigger
  localparam logic [1:0] ST_WAIT = 2'd1;  // trigger armed, waiting for sample 0
  localparam logic [1:0] ST_CAPT = 2'd2;  // writing samples 1..SAMP_MAX
  localparam logic [1:0] ST_DONE = 2'd3;  // one-cycle event bookkeeping

  // Width of the pending-trigger counter depends on the queueing option.
`ifdef DAQ_TRIG_QUEUE_EN
  localparam int PW = 3;
`else
  localparam int PW = 1;
`endif

  localparam logic [3:0] MAX_EVT_C = 4'(MAX_EVT);

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [PW-1:0] pend_reg;
  logic [PW-1:0] pend_next;
  logic [6:0]    samp_reg;
  logic [6:0]    samp_next;
  logic [3:0]    evt_cnt_reg;
  logic [3:0]    evt_cnt_next;
  logic          ovfl_reg;
  logic          ovfl_next;

  // Per-cycle decisions
  logic          wr_next;     // pulse WR_ENA next cycle
  logic          load_next;   // capture ADC_DIN into DOUT next cycle
  logic          l1a_acc;     // this L1A is counted in the pending counter
  logic          pend_dec;    // a pending trigger is consumed this cycle
  logic          evt_inc;     // a complete event is committed this cycle
  logic          evt_dec;     // the reader releases an event this cycle
  logic          evt_full;    // event store cannot take another event

  // The store is full once MAX_EVT events are held. The >= compare also keeps
  // the machine blocked if the count were ever to read above the limit.
  assign evt_full = (evt_cnt_reg >= MAX_EVT_C);

  // --------------------------------------------------------------------------
  // Trigger acceptance
  // --------------------------------------------------------------------------
`ifdef DAQ_TRIG_QUEUE_EN
  // Queue mode: any L1A is counted unless the 3-bit queue is saturated.
  // Full-queue detection uses the registered count, so a trigger consumed in
  // the same cycle does not make room for it.
  assign l1a_acc = L1A && (pend_reg != {PW{1'b1}});
`else
  // Single-trigger mode: only an idle machine with nothing pending and room
  // for one more event takes a trigger. Everything else is an overflow.
  assign l1a_acc = L1A && (state_reg == ST_IDLE) && (pend_reg == '0) && !evt_full;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    samp_next  = samp_reg;
    pend_dec   = 1'b0;
    evt_inc    = 1'b0;
    wr_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // A trigger arriving this cycle is included so an idle machine arms
        // one cycle after the L1A. A full event store keeps the trigger
        // pending in the counter until the reader frees a slot.
        if (((pend_reg != '0) || l1a_acc) && !evt_full) begin
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // The first valid sample after arming is sample 0 of the event. It
        // consumes the pending trigger.
        if (ADC_VALID) begin
          wr_next   = 1'b1;
          pend_dec  = 1'b1;
          samp_next = 7'd1;
          if (SAMP_MAX == 7'd0) begin
            state_next = ST_DONE;   // one-sample event
          end else begin
            state_next = ST_CAPT;
          end
        end
      end

      ST_CAPT: begin
        if (ADC_VALID) begin
          wr_next = 1'b1;
          // >= rather than == so that a SAMP_MAX lowered mid-event still
          // terminates the event instead of running until the counter wraps.
          if (samp_reg >= SAMP_MAX) begin
            state_next = ST_DONE;
          end else begin
            samp_next = samp_reg + 7'd1;
          end
        end
      end

      ST_DONE: begin
        // Samples arriving here are deliberately ignored; the next event
        // cannot start before the machine passes through IDLE.
        evt_inc    = 1'b1;
        samp_next  = 7'd0;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A done pulse with nothing stored is meaningless and is dropped. That
    // test is made before netting against a concurrent commit.
    evt_dec = EVT_DONE && (evt_cnt_reg != 4'd0);

    pend_next    = pend_reg + PW'(l1a_acc) - PW'(pend_dec);
    evt_cnt_next = evt_cnt_reg + 4'(evt_inc) - 4'(evt_dec);
    ovfl_next    = ovfl_reg | (L1A && !l1a_acc);
    load_next    = wr_next;

    // JTAG direct-write mode overrides the capture path entirely. Any partial
    // event is abandoned without being counted, and the samples already
    // written stay in the FIFOs. L1A is not an overflow here because
    // triggers are not expected in this mode.
    if (JTAG_MODE) begin
      state_next   = ST_IDLE;
      pend_next    = '0;
      samp_next    = 7'd0;
      evt_cnt_next = evt_cnt_reg;
      ovfl_next    = ovfl_reg;
      wr_next      = WR_FIFO;
      load_next    = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg   <= ST_IDLE;
      pend_reg    <= '0;
      samp_reg    <= 7'd0;
      evt_cnt_reg <= 4'd0;
      ovfl_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pend_reg    <= pend_next;
      samp_reg    <= samp_next;
      evt_cnt_reg <= evt_cnt_next;
      ovfl_reg    <= ovfl_next;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel write lanes
  // Each channel has its own data register and write-enable flop. All lanes
  // share the same load/enable decision, so the enables are identical. The
  // per-lane replication lets the placer keep each lane next to its FIFO.
  // --------------------------------------------------------------------------
  logic [DW-1:0] dout_reg [NCHAN];
  logic          wr_ena_reg [NCHAN];

  generate
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_lane
      always_ff @(posedge CLK) begin
        if (!RST) begin
          dout_reg[gi]   <= '0;
          wr_ena_reg[gi] <= 1'b0;
        end else begin
          wr_ena_reg[gi] <= wr_next;
          if (load_next) begin
            dout_reg[gi] <= ADC_DIN[gi*DW +: DW];
          end
        end
      end

      assign DOUT[gi*DW +: DW] = dout_reg[gi];
      assign WR_ENA[gi]        = wr_ena_reg[gi];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Status outputs
  // --------------------------------------------------------------------------
  assign EVT_CNT = evt_cnt_reg;
  assign RDY     = (evt_cnt_reg != 4'd0);
  assign OVFL    = ovfl_reg;

endmodule

// File: tb/tb_daq_chan_fifo_writer.sv
// ============================================================================
// tb_daq_chan_fifo_writer
// Self-checking bench for daq_chan_fifo_writer: a table of hand-derived
// vectors, directed multi-cycle sequences and randomized traffic checked
// against an event-level reference model.
// ============================================================================
module tb_daq_chan_fifo_writer;

  localparam int NCHAN   = 16;
  localparam int DW      = 12;
  localparam int MAX_EVT = 8;
  localparam int BW      = NCHAN * DW;

`ifdef DAQ_TRIG_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic             CLK;
  logic             RST;
  logic             JTAG_MODE;
  logic             WR_FIFO;
  logic             L1A;
  logic [6:0]       SAMP_MAX;
  logic             ADC_VALID;
  logic [BW-1:0]    ADC_DIN;
  logic             EVT_DONE;
  logic [NCHAN-1:0] WR_ENA;
  logic [BW-1:0]    DOUT;
  logic             RDY;
  logic [3:0]       EVT_CNT;
  logic             OVFL;

  daq_chan_fifo_writer #(.NCHAN(NCHAN), .DW(DW), .MAX_EVT(MAX_EVT)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .JTAG_MODE (JTAG_MODE),
    .WR_FIFO   (WR_FIFO),
    .L1A       (L1A),
    .SAMP_MAX  (SAMP_MAX),
    .ADC_VALID (ADC_VALID),
    .ADC_DIN   (ADC_DIN),
    .EVT_DONE  (EVT_DONE),
    .WR_ENA    (WR_ENA),
    .DOUT      (DOUT),
    .RDY       (RDY),
    .EVT_CNT   (EVT_CNT),
    .OVFL      (OVFL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int wr_seen  = 0;
  int din_seq  = 0;

  // --------------------------------------------------------------------------
  // Reference model: tracks the event in terms of "armed", samples written so
  // far and a commit cycle, plus trigger and event counts as plain integers.
  // --------------------------------------------------------------------------
  int            m_pend;
  bit            m_busy;    // trigger armed, event in progress
  int            m_nwr;     // samples written for the current event
  bit            m_fin;     // commit cycle after the last sample
  int            m_evts;
  bit            m_ovfl;
  bit            m_wr;
  logic [BW-1:0] m_dout;

  task automatic model_step();
    bit fin_old;
    int evts_old;
    int pend_eff;
    bit acc;
    if (!RST) begin
      m_pend = 0; m_busy = 0; m_nwr = 0; m_fin = 0;
      m_evts = 0; m_ovfl = 0; m_wr = 0; m_dout = '0;
    end else if (JTAG_MODE) begin
      m_pend = 0; m_busy = 0; m_nwr = 0; m_fin = 0;
      m_wr   = WR_FIFO;
      m_dout = ADC_DIN;
    end else begin
      fin_old  = m_fin;
      evts_old = m_evts;
      if (QUEUE) acc = L1A && (m_pend < 7);
      else       acc = L1A && !m_busy && !m_fin && (m_pend == 0) && (evts_old < MAX_EVT);
      if (L1A && !acc) m_ovfl = 1;
      pend_eff = m_pend + (acc ? 1 : 0);
      m_wr = 0;
      if (m_fin) begin
        m_fin = 0;
      end else if (m_busy) begin
        if (ADC_VALID) begin
          m_wr   = 1;
          m_dout = ADC_DIN;
          if (m_nwr == 0) pend_eff = pend_eff - 1;
          m_nwr = m_nwr + 1;
          if (m_nwr == int'(SAMP_MAX) + 1) begin
            m_busy = 0; m_fin = 1; m_nwr = 0;
          end
        end
      end else if (pend_eff > 0 && evts_old < MAX_EVT) begin
        m_busy = 1;
      end
      m_evts = evts_old + (fin_old ? 1 : 0) - ((EVT_DONE && evts_old > 0) ? 1 : 0);
      m_pend = pend_eff;
    end
  endtask

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    check("model_wr_ena",  BW'(WR_ENA), BW'(m_wr ? 16'hFFFF : 16'h0000));
    check("model_dout",    DOUT, m_dout);
    check("model_evt_cnt", BW'(EVT_CNT), BW'(m_evts));
    check("model_rdy",     BW'(RDY), BW'(m_evts != 0));
    check("model_ovfl",    BW'(OVFL), BW'(m_ovfl));
  endtask

  // One clock: the model sees the same inputs the DUT samples, outputs are
  // read 1 time unit after the edge, and new inputs are driven afterwards.
  task automatic tick(input bit chk);
    @(posedge CLK);
    model_step();
    #1;
    if (WR_ENA != '0) wr_seen++;
    if (chk) compare_model();
  endtask

  function automatic logic [BW-1:0] make_din(input int seq);
    logic [BW-1:0] d;
    for (int ch = 0; ch < NCHAN; ch++) d[ch*DW +: DW] = DW'(seq * 17 + ch * 5 + 1);
    return d;
  endfunction

  function automatic logic [BW-1:0] rand_din();
    logic [BW-1:0] d;
    for (int ch = 0; ch < NCHAN; ch++) d[ch*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  task automatic idle_inputs();
    JTAG_MODE = 0; WR_FIFO = 0; L1A = 0; ADC_VALID = 0; EVT_DONE = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 0;
    tick(1);
    tick(1);
    RST = 1;
  endtask

  task automatic pulse_l1a();
    L1A = 1;
    tick(1);
    L1A = 0;
  endtask

  task automatic send_samples(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      ADC_VALID = 1;
      ADC_DIN   = make_din(din_seq);
      din_seq++;
      tick(1);
      ADC_VALID = 0;
      repeat (gap) tick(1);
    end
  endtask

  typedef struct {
    bit         rst_n;
    bit         jtag;
    bit         wr_fifo;
    bit         l1a;
    bit         valid;
    bit         evt_done;
    logic [11:0] din;
    bit         e_wr;
    logic [11:0] e_dout;
    logic [3:0] e_cnt;
    bit         e_ovfl;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int w0;
    logic [11:0] word;

    RST = 0; SAMP_MAX = 7'd1; ADC_DIN = '0;
    idle_inputs();

    // rst jtag wrf l1a vld edn din      wr dout    cnt ovfl   (SAMP_MAX = 1)
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 12'h000, 0, 12'h000, 4'd0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 12'h000, 0, 12'h000, 4'd0, 0};
    tbl[2]  = '{1, 0, 0, 1, 1, 0, 12'h111, 0, 12'h000, 4'd0, 0};
    tbl[3]  = '{1, 0, 0, 0, 1, 0, 12'h222, 1, 12'h222, 4'd0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 0, 12'h000, 0, 12'h222, 4'd0, 0};
    tbl[5]  = '{1, 0, 0, 0, 1, 0, 12'h333, 1, 12'h333, 4'd0, 0};
    tbl[6]  = '{1, 0, 0, 0, 1, 0, 12'h444, 0, 12'h333, 4'd1, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 1, 12'h000, 0, 12'h333, 4'd0, 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 1, 12'h000, 0, 12'h333, 4'd0, 0};
    tbl[9]  = '{1, 1, 1, 1, 0, 0, 12'h555, 1, 12'h555, 4'd0, 0};
    tbl[10] = '{1, 1, 0, 0, 0, 0, 12'h666, 0, 12'h666, 4'd0, 0};
    tbl[11] = '{1, 0, 0, 1, 0, 0, 12'h000, 0, 12'h666, 4'd0, 0};
    tbl[12] = '{1, 0, 0, 0, 1, 0, 12'h777, 1, 12'h777, 4'd0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 12'h000, 0, 12'h000, 4'd0, 0};
    tbl[14] = '{1, 0, 0, 0, 1, 0, 12'h888, 0, 12'h000, 4'd0, 0};

    for (int v = 0; v < 15; v++) begin
      RST = tbl[v].rst_n; JTAG_MODE = tbl[v].jtag; WR_FIFO = tbl[v].wr_fifo;
      L1A = tbl[v].l1a; ADC_VALID = tbl[v].valid; EVT_DONE = tbl[v].evt_done;
      word = tbl[v].din;
      ADC_DIN = {NCHAN{word}};
      tick(0);
      word = tbl[v].e_dout;
      check($sformatf("vec%0d_wr_ena", v), BW'(WR_ENA), BW'(tbl[v].e_wr ? 16'hFFFF : 16'h0000));
      check($sformatf("vec%0d_dout", v), DOUT, {NCHAN{word}});
      check($sformatf("vec%0d_evt_cnt", v), BW'(EVT_CNT), BW'(tbl[v].e_cnt));
      check($sformatf("vec%0d_rdy", v), BW'(RDY), BW'(tbl[v].e_cnt != 4'd0));
      check($sformatf("vec%0d_ovfl", v), BW'(OVFL), BW'(tbl[v].e_ovfl));
      $display("vec %0d: wr_ena=%h dout0=%h evt_cnt=%0d ovfl=%0d", v, WR_ENA, DOUT[11:0], EVT_CNT, OVFL);
    end
    idle_inputs();

    // A: 8-sample event, ADC_VALID every 4 cycles
    do_reset();
    SAMP_MAX = 7'd7;
    w0 = wr_seen;
    pulse_l1a();
    send_samples(8, 3);
    check("seqA_writes", BW'(wr_seen - w0), BW'(8));
    check("seqA_evt_cnt", BW'(EVT_CNT), BW'(1));
    check("seqA_rdy", BW'(RDY), BW'(1));
    $display("seqA: writes=%0d evt_cnt=%0d", wr_seen - w0, EVT_CNT);

    // B: commit coincident with EVT_DONE, then a lone EVT_DONE at zero
    SAMP_MAX = 7'd0;
    pulse_l1a();
    ADC_VALID = 1; ADC_DIN = make_din(din_seq); din_seq++;
    tick(1);
    ADC_VALID = 0; EVT_DONE = 1;
    tick(1);
    EVT_DONE = 0;
    check("seqB_coincident_cnt", BW'(EVT_CNT), BW'(1));
    EVT_DONE = 1;
    tick(1);
    tick(1);
    EVT_DONE = 0;
    check("seqB_zero_cnt", BW'(EVT_CNT), BW'(0));
    check("seqB_zero_rdy", BW'(RDY), BW'(0));
    $display("seqB: evt_cnt=%0d rdy=%0d", EVT_CNT, RDY);

    // C: fill to MAX_EVT, then a trigger while full
    for (int i = 0; i < MAX_EVT; i++) begin
      pulse_l1a();
      send_samples(1, 2);
    end
    check("seqC_full_cnt", BW'(EVT_CNT), BW'(MAX_EVT));
    w0 = wr_seen;
    pulse_l1a();
    send_samples(2, 3);
    check("seqC_full_no_write", BW'(wr_seen - w0), BW'(0));
    check("seqC_full_ovfl", BW'(OVFL), BW'(QUEUE ? 0 : 1));
    EVT_DONE = 1;
    tick(1);
    EVT_DONE = 0;
    tick(1);
    w0 = wr_seen;
    send_samples(1, 3);
    check("seqC_resume_writes", BW'(wr_seen - w0), BW'(QUEUE ? 1 : 0));
    check("seqC_resume_cnt", BW'(EVT_CNT), BW'(QUEUE ? 8 : 7));
    $display("seqC: evt_cnt=%0d ovfl=%0d", EVT_CNT, OVFL);

    // D: three extra triggers during one capture
    do_reset();
    SAMP_MAX = 7'd3;
    w0 = wr_seen;
    pulse_l1a();
    for (int i = 0; i < 16; i++) begin
      ADC_VALID = 1; ADC_DIN = make_din(din_seq); din_seq++;
      tick(1);
      ADC_VALID = 0;
      for (int g = 0; g < 3; g++) begin
        L1A = (i < 3) && (g == 0);
        tick(1);
        L1A = 0;
      end
    end
    tick(1);
    check("seqD_writes", BW'(wr_seen - w0), BW'(QUEUE ? 16 : 4));
    check("seqD_evt_cnt", BW'(EVT_CNT), BW'(QUEUE ? 4 : 1));
    check("seqD_ovfl", BW'(OVFL), BW'(QUEUE ? 0 : 1));
    $display("seqD: writes=%0d evt_cnt=%0d ovfl=%0d", wr_seen - w0, EVT_CNT, OVFL);

    // E: JTAG direct writes, then JTAG raised mid-capture
    do_reset();
    SAMP_MAX = 7'd0;
    pulse_l1a();
    send_samples(1, 2);
    w0 = wr_seen;
    JTAG_MODE = 1;
    for (int i = 0; i < 10; i++) begin
      WR_FIFO = (i % 2 == 1);
      L1A     = (i == 4);
      ADC_DIN = make_din(din_seq); din_seq++;
      tick(1);
    end
    WR_FIFO = 0; L1A = 0; JTAG_MODE = 0;
    tick(1);
    send_samples(1, 3);
    check("seqE_jtag_writes", BW'(wr_seen - w0), BW'(5));
    check("seqE_jtag_cnt", BW'(EVT_CNT), BW'(1));
    check("seqE_jtag_ovfl", BW'(OVFL), BW'(0));
    SAMP_MAX = 7'd7;
    pulse_l1a();
    send_samples(3, 3);
    w0 = wr_seen;
    JTAG_MODE = 1;
    send_samples(2, 3);
    JTAG_MODE = 0;
    send_samples(4, 3);
    check("seqE_abort_writes", BW'(wr_seen - w0), BW'(0));
    check("seqE_abort_cnt", BW'(EVT_CNT), BW'(1));
    $display("seqE: evt_cnt=%0d", EVT_CNT);

    // F: reset mid-capture, then a fresh event
    do_reset();
    SAMP_MAX = 7'd3;
    pulse_l1a();
    send_samples(2, 3);
    RST = 0;
    tick(1);
    check("seqF_rst_wr_ena", BW'(WR_ENA), BW'(0));
    check("seqF_rst_dout", DOUT, BW'(0));
    check("seqF_rst_cnt", BW'(EVT_CNT), BW'(0));
    check("seqF_rst_rdy", BW'(RDY), BW'(0));
    check("seqF_rst_ovfl", BW'(OVFL), BW'(0));
    RST = 1;
    w0 = wr_seen;
    pulse_l1a();
    send_samples(4, 3);
    check("seqF_fresh_writes", BW'(wr_seen - w0), BW'(4));
    check("seqF_fresh_cnt", BW'(EVT_CNT), BW'(1));
    $display("seqF: writes=%0d evt_cnt=%0d", wr_seen - w0, EVT_CNT);

    // Randomized traffic against the reference model
    for (int blk = 0; blk < 8; blk++) begin
      SAMP_MAX = 7'($urandom_range(0, 3));
      do_reset();
      for (int c = 0; c < 400; c++) begin
        L1A       = ($urandom_range(0, 7) == 0);
        ADC_VALID = ($urandom_range(0, 2) == 0);
        EVT_DONE  = (m_evts > 0) && ($urandom_range(0, 5) == 0);
        JTAG_MODE = ($urandom_range(0, 49) == 0);
        WR_FIFO   = ($urandom_range(0, 1) == 1);
        RST       = ($urandom_range(0, 299) != 0);
        ADC_DIN   = rand_din();
        tick(1);
      end
      RST = 1;
      $display("random block %0d: samp_max=%0d evt_cnt=%0d ovfl=%0d", blk, SAMP_MAX, EVT_CNT, OVFL);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
